// File: rtl/dp_feeder.sv
// dp_feeder: streams operand chunks into a fixed-latency dp_unit and sums the
// per-chunk dot products into one result per vector. A tag pipe tracks which
// dp_unit outputs carry real data. A small first-word-fall-through FIFO returns
// the results. A credit counter keeps that FIFO from ever overflowing.
module dp_feeder #(
    parameter int N_MUL     = 4,
    parameter int DW_MUL    = 8,
    parameter int DW_ADD    = 32,
    parameter int DW_ACC    = 32,
    parameter int DP_LAT    = 4 + $clog2(N_MUL),
    parameter int RES_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_MUL*DW_MUL-1:0] s_a,
    input  logic [N_MUL*DW_MUL-1:0] s_b,
    input  logic                    s_last,
    output logic                    dp_enable,
    output logic [1:0]              dp_in_valid,
    output logic [N_MUL*DW_MUL-1:0] dp_in_a,
    output logic [N_MUL*DW_MUL-1:0] dp_in_b,
    input  logic [DW_ADD-1:0]       dp_out,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DW_ACC-1:0]       r_data
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = PW + 1;

    // Enable / issue registers
    logic                    r_enable;
    logic [N_MUL*DW_MUL-1:0] r_in_a;
    logic [N_MUL*DW_MUL-1:0] r_in_b;

    // Tag pipe: one {vld, last} pair per dp_unit pipeline stage
    logic [DP_LAT-1:0]       r_tag_vld;
    logic [DP_LAT-1:0]       r_tag_last;

    // Accumulator and credit counter
    logic [DW_ACC-1:0]       r_acc;
    logic [CW-1:0]           r_pending;

    // Result FIFO storage and pointers (extra MSB separates full from empty)
    logic [DW_ACC-1:0]       r_mem [RES_DEPTH];
    logic [CW-1:0]           r_wr_ptr;
    logic [CW-1:0]           r_rd_ptr;

    logic                    w_accept;
    logic                    w_credit_take;
    logic                    w_pop;
    logic                    w_tag_hit;
    logic                    w_push;
    logic                    w_empty;
    logic [DW_ACC-1:0]       w_ext;
    logic [DW_ACC-1:0]       w_sum;

    // A credit is only needed once a vector is closed by its last chunk; an
    // open vector cannot produce a FIFO entry until then.
    assign s_ready       = (r_pending < CW'(RES_DEPTH)) & r_enable;
    assign w_accept      = s_valid & s_ready;
    assign w_credit_take = w_accept & s_last;
    assign w_pop         = r_valid & r_ready;

    // The dp_unit's early-valid protocol: valid goes out in the accept cycle,
    // data follows one cycle later from the issue registers.
    assign dp_in_valid = {w_accept, w_accept};
    assign dp_in_a     = r_in_a;
    assign dp_in_b     = r_in_b;
    assign dp_enable   = r_enable;

    assign w_tag_hit = r_tag_vld[DP_LAT-1];
    assign w_push    = w_tag_hit & r_tag_last[DP_LAT-1];
    assign w_ext     = DW_ACC'($signed(dp_out));
    assign w_sum     = r_acc + w_ext;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign r_valid = ~w_empty;
    assign r_data  = w_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

    // Enable the dp_unit on the first edge out of reset and keep it running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_enable <= 1'b0;
        else       r_enable <= 1'b1;
    end

    // Capture operands at the accept edge; they hold until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_a <= '0;
            r_in_b <= '0;
        end else if (w_accept) begin
            r_in_a <= s_a;
            r_in_b <= s_b;
        end
    end

    // Tag pipe shifts every cycle so the last stage lines up with dp_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else begin
            r_tag_vld  <= {r_tag_vld[DP_LAT-2:0],  w_accept};
            r_tag_last <= {r_tag_last[DP_LAT-2:0], s_last};
        end
    end

    // Sum tagged dp_out values; a last tag closes the vector and restarts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_tag_hit) begin
            r_acc <= r_tag_last[DP_LAT-1] ? '0 : w_sum;
        end
    end

    // Credit counter: closed vectors not yet popped (in flight or queued)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_credit_take && !w_pop) begin
            r_pending <= r_pending + CW'(1);
        end else if (!w_credit_take && w_pop) begin
            r_pending <= r_pending - CW'(1);
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_sum;
    end

    // FIFO pointer update; credits guarantee a push never meets a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

endmodule

// File: tb/tb_dp_feeder.sv
// Bench for dp_feeder: an ideal dp_unit model drives dp_out, a queue-based
// reference tracks expected results and timing, and directed tests pin the
// reference with hand-computed literals.
module tb_dp_feeder;

    localparam int N_MUL     = 4;
    localparam int DW_MUL    = 8;
    localparam int DW_ADD    = 32;
    localparam int DW_ACC    = 32;
    localparam int DP_LAT    = 6;
    localparam int RES_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_last;
    logic        dp_enable;
    logic [1:0]  dp_in_valid;
    logic [31:0] dp_in_a;
    logic [31:0] dp_in_b;
    logic [31:0] dp_out;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dp_feeder #(
        .N_MUL(N_MUL), .DW_MUL(DW_MUL), .DW_ADD(DW_ADD),
        .DW_ACC(DW_ACC), .DP_LAT(DP_LAT), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .dp_enable(dp_enable), .dp_in_valid(dp_in_valid),
        .dp_in_a(dp_in_a), .dp_in_b(dp_in_b), .dp_out(dp_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] v;
        v = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
        return v;
    endfunction

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < N_MUL; i++)
            s += int'($signed(a[i*DW_MUL +: DW_MUL])) * int'($signed(b[i*DW_MUL +: DW_MUL]));
        return 32'(s);
    endfunction

    // Ideal dp_unit: valid arrives one cycle before data; the product is
    // presented so it is sampled DP_LAT edges after the accept edge. Idle
    // slots carry random garbage which the feeder must ignore.
    logic        v_d;
    logic [31:0] p [DP_LAT-1];
    always @(posedge clk) begin
        v_d  <= dp_in_valid[1];
        p[0] <= v_d ? dot(dp_in_a, dp_in_b) : $urandom;
        for (int k = 1; k < DP_LAT-1; k++) p[k] <= p[k-1];
    end
    assign dp_out = p[DP_LAT-2];

    // Reference: expected enable state, result queue with availability cycle
    logic        en_m;
    logic [31:0] run;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [31:0] exp_val [$];
    int          exp_at  [$];

    always @(posedge clk or posedge reset) begin
        if (reset) en_m <= 1'b0;
        else       en_m <= 1'b1;
    end

    // Compare process: check every output each cycle, then advance the model
    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_rv;
        logic [31:0] exp_rd;
        if (reset) begin
            exp_val.delete();
            exp_at.delete();
            run    = '0;
            last_a = '0;
            last_b = '0;
        end else begin
            exp_rdy = en_m && (exp_val.size() < RES_DEPTH);
            exp_rv  = (exp_val.size() > 0) && (exp_at[0] <= cyc);
            exp_rd  = exp_rv ? exp_val[0] : 32'd0;
            chk("s_ready",     32'(s_ready),     32'(exp_rdy));
            chk("dp_enable",   32'(dp_enable),   32'(en_m));
            chk("dp_in_valid", 32'(dp_in_valid), 32'({2{s_valid & exp_rdy}}));
            chk("dp_in_a",     dp_in_a,          last_a);
            chk("dp_in_b",     dp_in_b,          last_b);
            chk("r_valid",     32'(r_valid),     32'(exp_rv));
            chk("r_data",      r_data,           exp_rd);
            if (exp_rv && r_ready) begin
                void'(exp_val.pop_front());
                void'(exp_at.pop_front());
            end
            if (s_valid && exp_rdy) begin
                run    = run + dot(s_a, s_b);
                last_a = s_a;
                last_b = s_b;
                if (s_last) begin
                    exp_val.push_back(run);
                    exp_at.push_back(cyc + 1 + DP_LAT);
                    run = '0;
                end
            end
        end
    end

    int          acc_edge;
    logic [1:0]  acc_in_valid;
    int          n_acc;

    // Offer one chunk, waiting up to 'bound' cycles for it to be taken
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                        input int bound, output bit ok);
        s_a = a; s_b = b; s_last = last; s_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                acc_edge = cyc + 1;
                acc_in_valid = dp_in_valid;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; s_a = $urandom; s_b = $urandom;
    endtask

    // Wait for a result, check it against a literal, pop it
    task automatic get_result(input string nm, input logic [31:0] exp);
        bit seen;
        seen = 1'b0;
        r_ready = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (r_valid) seen = 1'b1;
        end
        if (seen) chk(nm, r_data, exp);
        else      chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic expect_ok(input string nm, input bit ok);
        chk(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit seen;
        int nfail;
        reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; r_ready = 1'b0;
        #2;
        chk("rst_dp_enable", 32'(dp_enable),   32'd0);
        chk("rst_in_valid",  32'(dp_in_valid), 32'd0);
        chk("rst_s_ready",   32'(s_ready),     32'd0);
        chk("rst_r_valid",   32'(r_valid),     32'd0);
        chk("rst_r_data",    r_data,           32'd0);
        chk("rst_dp_in_a",   dp_in_a,          32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("en_after_reset", 32'(dp_enable), 32'd1);

        // Single chunk: 1*5+2*6+3*7+4*8 = 70, visible DP_LAT edges after accept
        send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1, 10, ok);
        expect_ok("t1_accept", ok);
        chk("t1_in_valid", 32'(acc_in_valid), 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (r_valid) seen = 1'b1;
        end
        chk("t1_latency", 32'(cyc - acc_edge), 32'(DP_LAT));
        @(posedge clk); #1;
        get_result("t1_data", 32'd70);

        // Three back-to-back chunks: 8 - 12 - 127 = -131
        send(pk(1, 1, 1, 1),       pk(2, 2, 2, 2),     1'b0, 10, ok); expect_ok("t2_c0", ok);
        send(pk(-3, 0, 0, 0),      pk(4, 0, 0, 0),     1'b0, 10, ok); expect_ok("t2_c1", ok);
        send(pk(127, -128, 0, 0),  pk(127, 127, 0, 0), 1'b1, 10, ok); expect_ok("t2_c2", ok);
        get_result("t2_data", 32'(-131));
        repeat (10) @(posedge clk);
        #1 chk("t2_single_result", 32'(r_valid), 32'd0);

        // Gaps with random idle data: 23 + 23 = 46
        send(pk(2, 3, 0, 0), pk(4, 5, 0, 0), 1'b0, 10, ok); expect_ok("t3_c0", ok);
        repeat (2) begin
            s_a = $urandom; s_b = $urandom; s_last = 1'b1;
            @(posedge clk); #1;
        end
        s_last = 1'b0;
        send(pk(-1, 0, 0, 10), pk(7, 0, 0, 3), 1'b1, 10, ok); expect_ok("t3_c1", ok);
        get_result("t3_data", 32'd46);

        // Backpressure: vector k has result 3k; only 4 credits available
        n_acc = 0;
        for (int k = 1; k <= 5; k++) begin
            send(pk(k, 0, 0, 0), pk(3, 0, 0, 0), 1'b1, 10, ok);
            if (ok) n_acc++;
        end
        chk("t4_accepts_4", 32'(n_acc), 32'd4);
        @(negedge clk);
        chk("t4_s_ready_low", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_a = pk(5, 0, 0, 0); s_b = pk(3, 0, 0, 0); s_last = 1'b1; s_valid = 1'b1;
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        send(pk(5, 0, 0, 0), pk(3, 0, 0, 0), 1'b1, 10, ok);
        if (ok) n_acc++;
        send(pk(6, 0, 0, 0), pk(3, 0, 0, 0), 1'b1, 10, ok);
        if (ok) n_acc++;
        chk("t4_accepts_5", 32'(n_acc), 32'd5);
        for (int k = 2; k <= 5; k++) get_result("t4_order", 32'(3 * k));
        send(pk(6, 0, 0, 0), pk(3, 0, 0, 0), 1'b1, 10, ok); expect_ok("t4_c6", ok);
        get_result("t4_last", 32'd18);

        // Reset mid-vector with an unread result queued
        send(pk(2, 2, 0, 0), pk(3, 3, 0, 0), 1'b1, 10, ok); expect_ok("t5_pre", ok);
        repeat (10) @(posedge clk);
        #1 chk("t5_queued", 32'(r_valid), 32'd1);
        send(pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1'b0, 10, ok); expect_ok("t5_c0", ok);
        send(pk(6, 0, 0, 0), pk(6, 0, 0, 0), 1'b0, 10, ok); expect_ok("t5_c1", ok);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_dp_enable", 32'(dp_enable),   32'd0);
        chk("t5_rst_in_valid",  32'(dp_in_valid), 32'd0);
        chk("t5_rst_s_ready",   32'(s_ready),     32'd0);
        chk("t5_rst_r_valid",   32'(r_valid),     32'd0);
        chk("t5_rst_r_data",    r_data,           32'd0);
        chk("t5_rst_dp_in_a",   dp_in_a,          32'd0);
        chk("t5_rst_dp_in_b",   dp_in_b,          32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(pk(1, 0, 0, 0), pk(9, 0, 0, 0), 1'b1, 10, ok); expect_ok("t5_post", ok);
        get_result("t5_data", 32'd9);

        // Signed wrap: 32769 chunks of 65536 overflow to 0x80010000
        nfail = 0;
        for (int i = 0; i < 32769; i++) begin
            send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128),
                 (i == 32768), 4, ok);
            if (!ok) nfail++;
        end
        chk("t6_all_accepted", 32'(nfail), 32'd0);
        get_result("t6_wrap", 32'h8001_0000);

        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
